// File: rtl/credit_flit_sender.sv
// Credit-based wormhole flit sender: 1-cycle forward latency, 1 flit/cycle.
// Backpressure: ready_o drops when downstream credits reach zero; illegal framing is consumed and dropped.
package credit_flit_pkg;
  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [29:0] payload;
  } flit_t;
endpackage

module credit_flit_sender
  import credit_flit_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  flit_t            data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output flit_t            flit_o,
  output logic             valid_o,
  input  logic             credit_i,
  output logic [CNT_W-1:0] credits_o,
  output logic             busy_o,
  output logic             error_o
);

  localparam logic [CNT_W-1:0] MAX_CRED = CNT_W'(BUFFER_SIZE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_credits;
  logic [CNT_W-1:0] w_credits_nxt;
  flit_t            r_flit;
  logic             r_valid;
  logic             r_error;

  logic w_ready;
  logic w_accept;
  logic w_fwd;
  logic w_frame_err;
  logic w_overflow;

  // Ready depends only on registered credits, never on valid_i or credit_i.
  assign w_ready  = (r_credits != '0) && !rst;
  assign w_accept = valid_i && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        S_IDLE: if (data_i.flit_label == HEAD) w_state_nxt = S_PKT;
        S_PKT:  if (data_i.flit_label == TAIL) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Misframed flits are consumed (ready was high) but never forwarded, so they cost no credit.
  always_comb begin
    w_fwd       = 1'b0;
    w_frame_err = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (data_i.flit_label == HEAD || data_i.flit_label == HEADTAIL) begin
            w_fwd = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
        S_PKT: begin
          if (data_i.flit_label == BODY || data_i.flit_label == TAIL) begin
            w_fwd = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
        default: w_frame_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_credits_nxt = r_credits;
    w_overflow    = 1'b0;
    if (w_fwd && !credit_i) begin
      w_credits_nxt = r_credits - CNT_W'(1);
    end else if (!w_fwd && credit_i) begin
      if (r_credits == MAX_CRED) begin
        w_overflow = 1'b1;
      end else begin
        w_credits_nxt = r_credits + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= MAX_CRED;
      r_flit    <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_credits <= w_credits_nxt;
      r_valid   <= w_fwd;
      r_error   <= r_error | w_frame_err | w_overflow;
      if (w_fwd) begin
        r_flit <= data_i;
      end
    end
  end

  assign ready_o   = w_ready;
  assign flit_o    = r_flit;
  assign valid_o   = r_valid;
  assign credits_o = r_credits;
  assign busy_o    = (r_state == S_PKT);
  assign error_o   = r_error;

endmodule

// File: tb/tb_credit_flit_sender.sv
// Randomized + directed bench for credit_flit_sender with a packet/credit reference model and flit scoreboard.
module tb_credit_flit_sender;
  import credit_flit_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  flit_t      data_i = '0;
  logic       valid_i = 1'b0;
  logic       credit_i = 1'b0;
  logic       ready_o;
  flit_t      flit_o;
  logic       valid_o;
  logic [3:0] credits_o;
  logic       busy_o;
  logic       error_o;

  credit_flit_sender #(.BUFFER_SIZE(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .flit_o    (flit_o),
    .valid_o   (valid_o),
    .credit_i  (credit_i),
    .credits_o (credits_o),
    .busy_o    (busy_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  flit_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Reference model: credits available, whether a packet is open, sticky error.
  int m_cred = DEPTH;
  bit m_open = 1'b0;
  bit m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: check model vs outputs, drive inputs, advance the model.
  task automatic step(input bit r, input bit v, input flit_label_t lbl,
                      input logic [29:0] pl, input bit cr);
    bit legal;
    int fwd;
    int nxt;
    @(negedge clk);
    check("ready_o", 32'(ready_o), 32'((m_cred != 0) && !rst));
    check("credits_o", 32'(credits_o), 32'(m_cred));
    check("busy_o", 32'(busy_o), 32'(m_open));
    check("error_o", 32'(error_o), 32'(m_err));
    rst      = r;
    valid_i  = v;
    data_i   = '{flit_label: lbl, payload: pl};
    credit_i = cr;
    fwd      = 0;
    if (r) begin
      m_cred = DEPTH;
      m_open = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (v && m_cred != 0) begin
        legal = m_open ? (lbl == BODY || lbl == TAIL) : (lbl == HEAD || lbl == HEADTAIL);
        if (legal) begin
          fwd    = 1;
          m_open = (lbl == HEAD || lbl == BODY);
          exp_q.push_back(data_i);
        end else begin
          m_err = 1'b1;
        end
      end
      nxt = m_cred - fwd + int'(cr);
      if (nxt > DEPTH) begin
        nxt   = DEPTH;
        m_err = 1'b1;
      end
      m_cred = nxt;
    end
  endtask

  task automatic idle(input int n, input bit cr);
    repeat (n) step(1'b0, 1'b0, HEAD, 30'h0, cr);
  endtask

  // Monitor: every valid_o pulse must match the oldest expected flit; flit_o holds otherwise.
  flit_t last_flit = '0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        last_flit = '0;
        check("valid_o_reset", 32'(valid_o), 32'(0));
        check("flit_o_reset", 32'(flit_o), 32'(0));
      end else if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_flit: got %0h, expected no valid_o", flit_o);
        end else begin
          last_flit = exp_q.pop_front();
          check("flit_o", 32'(flit_o), 32'(last_flit));
        end
      end else begin
        check("flit_o_hold", 32'(flit_o), 32'(last_flit));
      end
    end
  end

  initial begin
    flit_label_t lbl;
    bit          r;
    bit          v;
    bit          cr;

    step(1'b1, 1'b0, HEAD, 30'h0, 1'b0);
    step(1'b1, 1'b0, HEAD, 30'h0, 1'b0);
    idle(2, 1'b0);

    // Four-flit packet with no returning credits.
    step(1'b0, 1'b1, HEAD, 30'h11, 1'b0);
    step(1'b0, 1'b1, BODY, 30'h12, 1'b0);
    step(1'b0, 1'b1, BODY, 30'h13, 1'b0);
    step(1'b0, 1'b1, TAIL, 30'h14, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Exhaust credits, then one credit pulse releases the stalled flit.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, HEADTAIL, 30'(32'h100 + i), 1'b0);
    step(1'b0, 1'b1, HEADTAIL, 30'h108, 1'b1);
    step(1'b0, 1'b1, HEADTAIL, 30'h108, 1'b0);
    idle(1, 1'b0);
    idle(8, 1'b1);

    // Forward and credit in the same cycle keep the count steady.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, HEADTAIL, 30'(32'h300 + i), 1'b1);
    idle(2, 1'b0);

    // Framing errors.
    step(1'b0, 1'b1, BODY, 30'h400, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, HEAD, 30'h401, 1'b0);
    step(1'b0, 1'b1, HEAD, 30'h402, 1'b0);
    step(1'b0, 1'b1, TAIL, 30'h403, 1'b0);
    idle(2, 1'b1);

    // Overflow, then reset in the middle of a packet.
    step(1'b1, 1'b0, HEAD, 30'h0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b1, HEAD, 30'h500, 1'b0);
    step(1'b0, 1'b1, BODY, 30'h501, 1'b0);
    step(1'b1, 1'b1, BODY, 30'h502, 1'b0);
    idle(2, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        lbl = flit_label_t'(2'($urandom_range(0, 3)));
      end else if (m_open) begin
        lbl = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
      end else begin
        lbl = ($urandom_range(0, 1) == 0) ? HEAD : HEADTAIL;
      end
      cr = ($urandom_range(0, 1) == 1) && (m_cred < DEPTH || $urandom_range(0, 19) == 0);
      step(r, v, lbl, 30'($urandom), cr);
    end

    idle(4, 1'b0);
    @(negedge clk);
    check("leftover_flits", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
